// File: rtl/accel_stream_dma_pkg.sv
// Shared types and address helpers for the streaming DMA controller.
// Pure declarations: no latency, no flow control of its own.
package accel_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        FILL_RD,
        FILL_PUT,
        DRAIN_GET,
        DRAIN_WR
    } dma_state_e;

    localparam logic DIR_FILL  = 1'b0;
    localparam logic DIR_DRAIN = 1'b1;

    // Each channel owns a source region followed by an equal-sized sink region.
    function automatic logic [63:0] region_base(input int unsigned ch, input int unsigned region_w);
        return 64'(ch) << (region_w + 1);
    endfunction

endpackage

// File: rtl/accel_stream_dma_rr_arbiter.sv
// Round-robin picker: highest priority goes to the requester just after 'last'.
// Purely combinational, zero latency; no backpressure (caller decides when to sample).
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    // Walk from the farthest candidate to the nearest so the nearest wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = N; i >= 1; i--) begin
            if (req[(int'(last) + i) % N]) begin
                gnt = N'(1) << ((int'(last) + i) % N);
                idx = IDX_W'((int'(last) + i) % N);
            end
        end
    end

endmodule

// File: rtl/accel_stream_dma.sv
// N-channel DMA between shared RAM and accelerator FIFOs, round-robin bounded bursts.
// 2 cycles per word plus IDLE/GRANT per burst; FIFO flags are sampled only between words.
module accel_stream_dma
    import accel_dma_pkg::*;
#(
    parameter int NUM_CH    = 3,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int REGION_W  = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [NUM_CH-1:0]        ch_enable,
    input  logic [NUM_CH-1:0]        to_full,
    input  logic [NUM_CH-1:0]        to_empty,
    input  logic [NUM_CH-1:0]        from_full,
    input  logic [NUM_CH-1:0]        from_empty,
    output logic [NUM_CH-1:0]        put_req,
    output logic [NUM_CH-1:0]        get_req,
    input  logic [NUM_CH*DATA_W-1:0] ch_data_in,
    output logic [NUM_CH*DATA_W-1:0] ch_data_out,
    output logic [ADDR_W-1:0]        addr,
    output logic                     ram_read_enable,
    output logic                     ram_write_enable,
    inout  wire  [DATA_W-1:0]        data_bus,
    output logic                     done_irq
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BW    = $clog2(BURST_LEN + 1);
    localparam logic [REGION_W:0] CNT_FULL = {1'b1, {REGION_W{1'b0}}};

    dma_state_e        state_q;
    logic [IDX_W-1:0]  ch_q, rr_q, gnt_idx;
    logic [BW-1:0]     burst_q, burst_d;
    logic [REGION_W:0] src_cnt_q [NUM_CH];
    logic [REGION_W:0] snk_cnt_q [NUM_CH];
    logic [REGION_W:0] src_d, snk_d;
    logic [NUM_CH-1:0] ch_enable_q, put_req_q, get_req_q;
    logic [NUM_CH-1:0] snk_full, ch_ok, fill_req, drain_req, drain_sel, any_req, gnt;
    logic [ADDR_W-1:0] addr_q;
    logic              rd_q, wr_q, done_irq_q;
    logic              fill_more, drain_more;
    logic [DATA_W-1:0] wr_dat;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [IDX_W-1:0] ch, input logic sink,
                                                    input logic [REGION_W:0] cnt);
        logic [63:0] a;
        a = region_base(32'(ch), REGION_W) + (sink ? (64'd1 << REGION_W) : 64'd0) + 64'(cnt);
        return ADDR_W'(a);
    endfunction

    // Fill wins a tie only while the accelerator input is starving and its output has room.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            snk_full[c]  = (snk_cnt_q[c] == CNT_FULL);
            ch_ok[c]     = ch_enable_q[c] && !snk_full[c];
            drain_req[c] = ch_ok[c] && !from_empty[c];
            fill_req[c]  = ch_ok[c] && !to_full[c] && (src_cnt_q[c] != CNT_FULL);
            drain_sel[c] = drain_req[c] &&
                           (from_full[c] || to_full[c] || !fill_req[c] || !to_empty[c]);
        end
    end

    assign any_req = drain_req | fill_req;
    assign burst_d = burst_q + 1'b1;
    assign src_d   = src_cnt_q[ch_q] + 1'b1;
    assign snk_d   = snk_cnt_q[ch_q] + 1'b1;

    assign fill_more  = (int'(burst_d) < BURST_LEN) && ch_ok[ch_q] && !to_full[ch_q] &&
                        (src_d != CNT_FULL);
    assign drain_more = (int'(burst_d) < BURST_LEN) && ch_ok[ch_q] && !from_empty[ch_q] &&
                        (snk_d != CNT_FULL);

    rr_arbiter #(.N(NUM_CH), .IDX_W(IDX_W)) u_arb (
        .req  (any_req),
        .last (rr_q),
        .gnt  (gnt),
        .idx  (gnt_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            rr_q        <= '0;
            burst_q     <= '0;
            ch_enable_q <= '1;
            put_req_q   <= '0;
            get_req_q   <= '0;
            addr_q      <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            done_irq_q  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                src_cnt_q[c] <= '0;
                snk_cnt_q[c] <= '0;
            end
        end else begin
            put_req_q   <= '0;
            get_req_q   <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            ch_enable_q <= ch_enable_q & ~snk_full;
            done_irq_q  <= |(ch_enable_q & snk_full);
            case (state_q)
                IDLE: begin
                    if (|any_req) state_q <= GRANT;
                end
                GRANT: begin
                    burst_q <= '0;
                    ch_q    <= gnt_idx;
                    if (!(|any_req)) begin
                        state_q <= IDLE;
                    end else if (drain_sel[gnt_idx] == DIR_DRAIN) begin
                        state_q   <= DRAIN_GET;
                        get_req_q <= gnt;
                    end else begin
                        state_q <= FILL_RD;
                        addr_q  <= word_addr(gnt_idx, 1'b0, src_cnt_q[gnt_idx]);
                        rd_q    <= 1'b1;
                    end
                end
                FILL_RD: begin
                    state_q   <= FILL_PUT;
                    put_req_q <= NUM_CH'(1) << ch_q;
                end
                FILL_PUT: begin
                    src_cnt_q[ch_q] <= src_d;
                    burst_q         <= burst_d;
                    if (fill_more) begin
                        state_q <= FILL_RD;
                        addr_q  <= word_addr(ch_q, 1'b0, src_d);
                        rd_q    <= 1'b1;
                    end else begin
                        rr_q    <= ch_q;
                        state_q <= IDLE;
                    end
                end
                DRAIN_GET: begin
                    state_q <= DRAIN_WR;
                    addr_q  <= word_addr(ch_q, 1'b1, snk_cnt_q[ch_q]);
                    wr_q    <= 1'b1;
                end
                DRAIN_WR: begin
                    snk_cnt_q[ch_q] <= snk_d;
                    burst_q         <= burst_d;
                    if (drain_more) begin
                        state_q   <= DRAIN_GET;
                        get_req_q <= NUM_CH'(1) << ch_q;
                    end else begin
                        rr_q    <= ch_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        wr_dat = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_q == IDX_W'(c)) wr_dat = ch_data_in[c*DATA_W +: DATA_W];
        end
    end

    // Read data is forwarded straight from the bus during the put cycle.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_out
        assign ch_data_out[c*DATA_W +: DATA_W] = put_req_q[c] ? data_bus : '0;
    end

    assign data_bus         = wr_q ? wr_dat : {DATA_W{1'bz}};
    assign ch_enable        = ch_enable_q;
    assign put_req          = put_req_q;
    assign get_req          = get_req_q;
    assign addr             = addr_q;
    assign ram_read_enable  = rd_q;
    assign ram_write_enable = wr_q;
    assign done_irq         = done_irq_q;

endmodule

// File: tb/tb_accel_stream_dma.sv
// Directed bench for accel_stream_dma: cycle table for fill bursts, hand sequences for the rest.
module tb_accel_stream_dma;

    localparam int NC = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam logic [DW-1:0] D0 = 32'hD0D0_0000;
    localparam logic [DW-1:0] D1 = 32'hD1D1_0001;
    localparam logic [DW-1:0] D2 = 32'hD2D2_0002;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic reset2 = 1'b0;
    always #5 clk = ~clk;

    logic [NC-1:0]    to_full, to_empty, from_full, from_empty;
    logic [NC-1:0]    ch_enable, put_req, get_req;
    logic [NC*DW-1:0] ch_data_in, ch_data_out;
    logic [AW-1:0]    addr;
    logic             ram_read_enable, ram_write_enable, done_irq;
    wire  [DW-1:0]    data_bus;
    logic             tb_drv;
    logic [DW-1:0]    tb_dat;
    assign data_bus = tb_drv ? tb_dat : {DW{1'bz}};

    logic [NC-1:0]    to_full2, to_empty2, from_full2, from_empty2;
    logic [NC-1:0]    ch_enable2, put_req2, get_req2;
    logic [NC*DW-1:0] ch_data_in2, ch_data_out2;
    logic [AW-1:0]    addr2;
    logic             ram_read_enable2, ram_write_enable2, done_irq2;
    wire  [DW-1:0]    data_bus2;

    accel_stream_dma dut (
        .clk(clk), .reset(reset), .ch_enable(ch_enable),
        .to_full(to_full), .to_empty(to_empty), .from_full(from_full), .from_empty(from_empty),
        .put_req(put_req), .get_req(get_req), .ch_data_in(ch_data_in), .ch_data_out(ch_data_out),
        .addr(addr), .ram_read_enable(ram_read_enable), .ram_write_enable(ram_write_enable),
        .data_bus(data_bus), .done_irq(done_irq)
    );

    accel_stream_dma #(.REGION_W(2)) dut2 (
        .clk(clk), .reset(reset2), .ch_enable(ch_enable2),
        .to_full(to_full2), .to_empty(to_empty2), .from_full(from_full2), .from_empty(from_empty2),
        .put_req(put_req2), .get_req(get_req2), .ch_data_in(ch_data_in2), .ch_data_out(ch_data_out2),
        .addr(addr2), .ram_read_enable(ram_read_enable2), .ram_write_enable(ram_write_enable2),
        .data_bus(data_bus2), .done_irq(done_irq2)
    );

    // RAM model: word at address a reads back as 0xA0000000 | a, one cycle after the read strobe.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            tb_drv <= 1'b0;
            tb_dat <= '0;
        end else begin
            tb_drv <= ram_read_enable;
            tb_dat <= 32'hA000_0000 | addr;
        end
    end

    function automatic int oh_idx(input logic [NC-1:0] v);
        for (int i = 0; i < NC; i++) if (v[i]) return i;
        return -1;
    endfunction

    logic [31:0] rd_addr_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_dat_q[$];
    int          put_ch_q[$];
    int          get_ch_q[$];
    int          overlap = 0;
    int          get2_cnt = 0, wr2_cnt = 0, done2_cnt = 0;
    logic [31:0] last_wr2 = '0;

    always @(posedge clk) begin
        if (ram_read_enable && ram_write_enable) overlap++;
        if (ram_read_enable) rd_addr_q.push_back(addr);
        if (ram_write_enable) begin
            wr_addr_q.push_back(addr);
            wr_dat_q.push_back(data_bus);
        end
        if (|put_req) put_ch_q.push_back(oh_idx(put_req));
        if (|get_req) get_ch_q.push_back(oh_idx(get_req));
        if (reset2) begin
            if (get_req2[0]) get2_cnt++;
            if (done_irq2) done2_cnt++;
            if (ram_write_enable2) begin
                wr2_cnt++;
                last_wr2 <= addr2;
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        rd_addr_q.delete();
        wr_addr_q.delete();
        wr_dat_q.delete();
        put_ch_q.delete();
        get_ch_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        clear_logs();
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        bit          rst;
        logic [2:0]  tf;
        logic        rd;
        logic [2:0]  put;
        logic [31:0] a;
        logic [31:0] d0;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rst, input logic [2:0] tf, input logic rd, input logic [2:0] put,
                       input logic [31:0] a, input logic [31:0] d0);
        vec_t v;
        v.rst = rst; v.tf = tf; v.rd = rd; v.put = put; v.a = a; v.d0 = d0;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int seen;
        to_full = '0; to_empty = '0; from_full = '0; from_empty = '1;
        ch_data_in = {D2, D1, D0};
        to_full2 = '1; to_empty2 = '0; from_full2 = '0; from_empty2 = 3'b110;
        ch_data_in2 = {D2, D1, D0};

        // Single channel fill burst, then re-arbitration back to ch0 at src_cnt 4.
        add(1, 3'b110, 0, 3'b000, 0, 0);
        add(0, 3'b110, 0, 3'b000, 0, 0);
        add(0, 3'b110, 0, 3'b000, 0, 0);
        for (int w = 0; w < 4; w++) begin
            add(0, 3'b110, 1, 3'b000, 32'(w), 0);
            add(0, 3'b110, 0, 3'b001, 0, 32'hA000_0000 | 32'(w));
        end
        add(0, 3'b110, 0, 3'b000, 0, 0);
        add(0, 3'b110, 0, 3'b000, 0, 0);
        add(0, 3'b110, 1, 3'b000, 32'd4, 0);
        // to_full[0] raised during the second word's put: burst stops after that word.
        add(1, 3'b110, 0, 3'b000, 0, 0);
        add(0, 3'b110, 0, 3'b000, 0, 0);
        add(0, 3'b110, 0, 3'b000, 0, 0);
        add(0, 3'b110, 1, 3'b000, 0, 0);
        add(0, 3'b110, 0, 3'b001, 0, 32'hA000_0000);
        add(0, 3'b110, 1, 3'b000, 1, 0);
        add(0, 3'b111, 0, 3'b001, 0, 32'hA000_0001);
        add(0, 3'b111, 0, 3'b000, 0, 0);
        add(0, 3'b111, 0, 3'b000, 0, 0);
        add(0, 3'b111, 0, 3'b000, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset = !tbl[i].rst;
            to_full = tbl[i].tf;
            #1;
            chk($sformatf("vec%0d rd", i), 64'(ram_read_enable), 64'(tbl[i].rd));
            chk($sformatf("vec%0d put", i), 64'(put_req), 64'(tbl[i].put));
            chk($sformatf("vec%0d wr", i), 64'(ram_write_enable), 64'd0);
            if (tbl[i].rd) chk($sformatf("vec%0d addr", i), 64'(addr), 64'(tbl[i].a));
            if (tbl[i].put[0]) chk($sformatf("vec%0d dout0", i), 64'(ch_data_out[31:0]), 64'(tbl[i].d0));
            if (tbl[i].rst) begin
                chk($sformatf("vec%0d rst ch_enable", i), 64'(ch_enable), 64'h7);
                chk($sformatf("vec%0d rst done_irq", i), 64'(done_irq), 64'd0);
                chk($sformatf("vec%0d rst addr", i), 64'(addr), 64'd0);
            end
        end

        // All three channels fill: bursts ch1, ch2, ch0, ch1.
        to_full = '0; from_empty = '1; from_full = '0; to_empty = '0;
        do_reset();
        repeat (60) @(negedge clk);
        chk("rr burst count", 64'(put_ch_q.size() >= 13), 64'd1);
        if (put_ch_q.size() >= 13 && rd_addr_q.size() >= 13) begin
            chk("rr burst0 ch", 64'(put_ch_q[0]), 64'd1);
            chk("rr burst1 ch", 64'(put_ch_q[4]), 64'd2);
            chk("rr burst2 ch", 64'(put_ch_q[8]), 64'd0);
            chk("rr burst3 ch", 64'(put_ch_q[12]), 64'd1);
            chk("rr burst0 addr", 64'(rd_addr_q[0]), 64'h200);
            chk("rr burst1 addr", 64'(rd_addr_q[4]), 64'h400);
            chk("rr burst2 addr", 64'(rd_addr_q[8]), 64'h000);
            chk("rr burst3 addr", 64'(rd_addr_q[12]), 64'h204);
        end

        // ch1 output FIFO full: drain is chosen over fill.
        to_full = 3'b101; from_empty = 3'b101; from_full = 3'b010; to_empty = 3'b000;
        do_reset();
        repeat (30) @(negedge clk);
        chk("drain count", 64'(wr_addr_q.size() >= 4 && get_ch_q.size() >= 1), 64'd1);
        if (wr_addr_q.size() >= 4 && get_ch_q.size() >= 1) begin
            chk("drain get ch", 64'(get_ch_q[0]), 64'd1);
            chk("drain wr addr0", 64'(wr_addr_q[0]), 64'h300);
            chk("drain wr data0", 64'(wr_dat_q[0]), 64'(D1));
            chk("drain wr addr3", 64'(wr_addr_q[3]), 64'h303);
        end
        chk("drain no reads", 64'(rd_addr_q.size()), 64'd0);

        // Reset in the middle of the second drain write.
        do_reset();
        seen = 0;
        for (int c = 0; c < 40 && seen == 0; c++) begin
            @(negedge clk);
            if (ram_write_enable && addr == 32'h301) seen = 1;
        end
        chk("midwr reached", 64'(seen), 64'd1);
        reset = 1'b0;
        #1;
        chk("midwr wr released", 64'(ram_write_enable), 64'd0);
        chk("midwr bus released", 64'(data_bus === D1), 64'd0);
        chk("midwr ch_enable", 64'(ch_enable), 64'h7);
        @(negedge clk);
        clear_logs();
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("midwr restart count", 64'(wr_addr_q.size() >= 1), 64'd1);
        if (wr_addr_q.size() >= 1) chk("midwr restart addr", 64'(wr_addr_q[0]), 64'h300);
        chk("no rd/wr overlap", 64'(overlap), 64'd0);

        // REGION_W=2 instance: ch0 drains its 4-word sink and retires.
        @(negedge clk);
        chk("r2 rst ch_enable", 64'(ch_enable2), 64'h7);
        reset2 = 1'b1;
        repeat (60) @(negedge clk);
        chk("r2 ch_enable", 64'(ch_enable2), 64'h6);
        chk("r2 done pulses", 64'(done2_cnt), 64'd1);
        chk("r2 get count", 64'(get2_cnt), 64'd4);
        chk("r2 wr count", 64'(wr2_cnt), 64'd4);
        chk("r2 last wr addr", 64'(last_wr2), 64'd7);
        chk("r2 done_irq low", 64'(done_irq2), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
